// File: rtl/vga_timing_pkg.sv
// 640x480@60 Hz raster timing constants and the shared phase type
// used by the horizontal and vertical sequencers.
package vga_timing_pkg;

    localparam int DEF_CLK_DIV   = 4;
    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam logic DEF_SYNC_POL = 1'b0;

    localparam int DEF_H_TOTAL =
        DEF_H_DISPLAY + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL =
        DEF_V_DISPLAY + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int DEF_H_SYNC_START = DEF_H_DISPLAY + DEF_H_FP;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
    localparam int DEF_V_SYNC_START = DEF_V_DISPLAY + DEF_V_FP;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_FP,
        ST_SYNC,
        ST_BP
    } phase_e;

    // Phase the counter enters when it takes value cnt; a zero count
    // always resynchronises to ACTIVE.
    function automatic phase_e next_phase(
        input phase_e     cur,
        input logic [9:0] cnt,
        input logic [9:0] fp_at,
        input logic [9:0] sy_at,
        input logic [9:0] bp_at
    );
        phase_e nxt;
        nxt = cur;
        if (cnt == 10'd0) begin
            nxt = ST_ACTIVE;
        end else begin
            unique case (cur)
                ST_ACTIVE: if (cnt == fp_at) nxt = ST_FP;
                ST_FP:     if (cnt == sy_at) nxt = ST_SYNC;
                ST_SYNC:   if (cnt == bp_at) nxt = ST_BP;
                ST_BP:     nxt = ST_BP;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/vga_sync_gen_pixel_tick_div.sv
// System-clock to pixel-rate divider; p_tick is high in the clock
// where the divider sits at its last count.
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] div_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else if (div_q == LAST) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign p_tick = (div_q == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster generator: pixel/line counters, phase sequencers and
// registered sync, blanking and strobe outputs.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   CLK_DIV   = DEF_CLK_DIV,
    parameter int   H_DISPLAY = DEF_H_DISPLAY,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_DISPLAY = DEF_V_DISPLAY,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter logic SYNC_POL  = DEF_SYNC_POL
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FP_AT = 10'(H_DISPLAY);
    localparam logic [9:0] H_SY_AT = 10'(H_DISPLAY + H_FP);
    localparam logic [9:0] H_BP_AT = 10'(H_DISPLAY + H_FP + H_SYNC);

    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FP_AT = 10'(V_DISPLAY);
    localparam logic [9:0] V_SY_AT = 10'(V_DISPLAY + V_FP);
    localparam logic [9:0] V_BP_AT = 10'(V_DISPLAY + V_FP + V_SYNC);

    logic       tick;
    logic       x_wrap;
    logic       y_wrap;
    logic [9:0] x_nxt;
    logic [9:0] y_nxt;
    logic [9:0] x_d;
    logic [9:0] y_d;
    phase_e     h_state;
    phase_e     v_state;
    phase_e     h_nxt;
    phase_e     v_nxt;

    pixel_tick_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .p_tick(tick)
    );

    // >= rather than == so an out-of-range count still wraps to 0
    assign x_wrap = (pix_x >= H_LAST);
    assign y_wrap = (pix_y >= V_LAST);
    assign x_nxt  = x_wrap ? 10'd0 : pix_x + 10'd1;
    assign y_nxt  = y_wrap ? 10'd0 : pix_y + 10'd1;

    always_comb begin
        x_d   = pix_x;
        y_d   = pix_y;
        h_nxt = h_state;
        v_nxt = v_state;
        if (tick) begin
            x_d   = x_nxt;
            h_nxt = next_phase(h_state, x_nxt, H_FP_AT, H_SY_AT, H_BP_AT);
            if (x_wrap) begin
                y_d   = y_nxt;
                v_nxt = next_phase(v_state, y_nxt, V_FP_AT, V_SY_AT, V_BP_AT);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_state     <= ST_BP;
            v_state     <= ST_BP;
            pix_x       <= H_LAST;
            pix_y       <= V_LAST;
            p_tick      <= 1'b0;
            video_on    <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            h_state     <= h_nxt;
            v_state     <= v_nxt;
            pix_x       <= x_d;
            pix_y       <= y_d;
            p_tick      <= tick;
            video_on    <= (h_nxt == ST_ACTIVE) && (v_nxt == ST_ACTIVE);
            hsync       <= (h_nxt == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
            vsync       <= (v_nxt == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
            line_start  <= tick && x_wrap;
            frame_start <= tick && x_wrap && y_wrap;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: a default 640x480 instance and a reduced-raster
// CLK_DIV=1 instance with active-high sync.
module tb_vga_sync_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       ls;
        logic       fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;

    logic       p_tick0, von0, hs0, vs0, ls0, fs0;
    logic [9:0] x0, y0;
    logic       p_tick1, von1, hs1, vs1, ls1, fs1;
    logic [9:0] x1, y1;

    int total = 0;
    int bad   = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1, g0, g1;

    always #5 clk = ~clk;

    vga_sync_gen u0 (
        .clk        (clk),
        .reset      (rst0),
        .p_tick     (p_tick0),
        .pix_x      (x0),
        .pix_y      (y0),
        .video_on   (von0),
        .hsync      (hs0),
        .vsync      (vs0),
        .line_start (ls0),
        .frame_start(fs0)
    );

    vga_sync_gen #(
        .CLK_DIV  (1),
        .H_DISPLAY(8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (2),
        .V_DISPLAY(4),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1),
        .SYNC_POL (1'b1)
    ) u1 (
        .clk        (clk),
        .reset      (rst1),
        .p_tick     (p_tick1),
        .pix_x      (x1),
        .pix_y      (y1),
        .video_on   (von1),
        .hsync      (hs1),
        .vsync      (vs1),
        .line_start (ls1),
        .frame_start(fs1)
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    function automatic exp_t mk0(input int i);
        exp_t e;
        e.x   = 10'(i % 800);
        e.y   = 10'(i / 800);
        e.hs  = !(e.x >= 656 && e.x < 752);
        e.vs  = !(e.y >= 490 && e.y < 492);
        e.von = (e.x < 640) && (e.y < 480);
        e.ls  = (e.x == 0);
        e.fs  = (e.x == 0) && (e.y == 0);
        return e;
    endfunction

    function automatic exp_t mk1(input int i);
        exp_t e;
        e.x   = 10'(i % 15);
        e.y   = 10'((i / 15) % 8);
        e.hs  = (e.x >= 10 && e.x < 13);
        e.vs  = (e.y >= 5 && e.y < 7);
        e.von = (e.x < 8) && (e.y < 4);
        e.ls  = (e.x == 0);
        e.fs  = (e.x == 0) && (e.y == 0);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst0 === 1'b1 && p_tick0 === 1'b1 && q0.size() > 0) begin
            e0 = q0.pop_front();
            g0 = {x0, y0, hs0, vs0, von0, ls0, fs0};
            total++;
            if (g0 !== e0) begin
                bad++;
                $display("FAIL u0_pix got x=%0d y=%0d hs%b vs%b von%b ls%b fs%b want x=%0d y=%0d hs%b vs%b von%b ls%b fs%b",
                    g0.x, g0.y, g0.hs, g0.vs, g0.von, g0.ls, g0.fs,
                    e0.x, e0.y, e0.hs, e0.vs, e0.von, e0.ls, e0.fs);
            end
        end
    end

    always @(negedge clk) begin
        if (rst1 === 1'b1 && p_tick1 === 1'b1 && q1.size() > 0) begin
            e1 = q1.pop_front();
            g1 = {x1, y1, hs1, vs1, von1, ls1, fs1};
            total++;
            if (g1 !== e1) begin
                bad++;
                $display("FAIL u1_pix got x=%0d y=%0d hs%b vs%b von%b ls%b fs%b want x=%0d y=%0d hs%b vs%b von%b ls%b fs%b",
                    g1.x, g1.y, g1.hs, g1.vs, g1.von, g1.ls, g1.fs,
                    e1.x, e1.y, e1.hs, e1.vs, e1.von, e1.ls, e1.fs);
            end
        end
    end

    initial begin
        int pre, ticks, hsl, vc, ls_n, off, found;
        int pt1, fs_cnt, fs_prev, fs_per, ls_cnt;

        rst0 = 1'b0;
        rst1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("u0_reset", {p_tick0, x0, y0, von0, hs0, vs0, ls0, fs0},
            {1'b0, 10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        chk("u1_reset", {p_tick1, x1, y1, von1, hs1, vs1, ls1, fs1},
            {1'b0, 10'd14, 10'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

        // one full line plus the first pixel of line 1
        for (int i = 0; i <= 800; i++) q0.push_back(mk0(i));
        rst0 = 1'b1;
        pre = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k < 4 && p_tick0) pre++;
        end
        chk("u0_early_tick", pre, 0);
        chk("u0_first_tick", {p_tick0, x0, y0, fs0, ls0, von0},
            {1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1});

        ticks = 0; hsl = 0; vc = 1; ls_n = 0; off = 0;
        for (int n = 1; n <= 3200; n++) begin
            @(negedge clk);
            if (p_tick0) begin
                ticks++;
                if (n % 4 != 0) off++;
                if (y0 == 10'd0 && !hs0) hsl++;
                if (y0 == 10'd0 && von0) vc++;
            end
            if (ls0) ls_n = n;
        end
        chk("u0_tick_count", ticks, 800);
        chk("u0_tick_period", off, 0);
        chk("u0_hsync_width", hsl, 96);
        chk("u0_video_px", vc, 640);
        chk("u0_line_period", ls_n, 3200);
        @(negedge clk);
        chk("u0_q_drain", q0.size(), 0);

        found = 0;
        for (int n = 0; n < 4000 && found == 0; n++) begin
            @(negedge clk);
            if (p_tick0 && x0 == 10'd700) found = 1;
        end
        chk("u0_find_700", found, 1);
        chk("u0_hsync_700", hs0, 0);
        rst0 = 1'b0;
        #1;
        chk("u0_async_rst", {hs0, x0, y0, p_tick0, ls0, fs0, von0},
            {1'b1, 10'd799, 10'd524, 1'b0, 1'b0, 1'b0, 1'b0});
        q0.push_back(mk0(0));
        @(negedge clk);
        rst0 = 1'b1;
        pre = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k < 4 && p_tick0) pre++;
        end
        chk("u0_rst_early", pre, 0);
        chk("u0_rst_restart", {p_tick0, x0, y0, fs0}, {1'b1, 10'd0, 10'd0, 1'b1});
        @(negedge clk);
        chk("u0_q_drain2", q0.size(), 0);

        // two full small frames plus the first pixel of the third
        for (int i = 0; i <= 240; i++) q1.push_back(mk1(i));
        rst1 = 1'b1;
        pt1 = 0; fs_cnt = 0; fs_prev = 0; fs_per = 0; ls_cnt = 0;
        for (int n = 1; n <= 241; n++) begin
            @(negedge clk);
            if (p_tick1) pt1++;
            if (ls1) ls_cnt++;
            if (fs1) begin
                if (fs_cnt > 0) fs_per = n - fs_prev;
                fs_prev = n;
                fs_cnt++;
            end
        end
        chk("u1_tick_const", pt1, 241);
        chk("u1_frame_cnt", fs_cnt, 3);
        chk("u1_frame_period", fs_per, 120);
        chk("u1_line_cnt", ls_cnt, 17);
        @(negedge clk);
        chk("u1_q_drain", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
